bomb_game_ctrl: RTL and testbench

Game sequencer for the bomb-dismantlement board. Owns the round state machine (power, arm, countdown, defuse/explode), paces the fuse, chooses the secret wire, judges wire cuts, and selects which frame source drives the 8x8 red/green matrix. Sits between the board switches/buttons and the dot-matrix renderers; the renderers only follow `disp_sel`, `fuse_level` and `bomb_en`.

---
 rtl/bomb_game_pkg.sv | 32 +++
 rtl/bomb_game_if.sv | 35 +++
 rtl/bomb_game_ctrl_fuse_timer.sv | 64 ++++++
 rtl/bomb_game_ctrl.sv | 155 +++++++++++++++
 tb/tb_bomb_game_ctrl.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bomb_game_pkg.sv
`default_nettype none
// ============================================================================
// Package  : bomb_game_pkg
// Brief    : Shared types and constants for the bomb game sequencer:
//            round state encoding, matrix frame select codes, LFSR taps.
// Revision : 1.0 - initial release
// ============================================================================
package bomb_game_pkg;

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_IDLE     = 3'd1,
        ST_COUNT    = 3'd2,
        ST_DEFUSED  = 3'd3,
        ST_EXPLODED = 3'd4
    } state_t;

    localparam logic [1:0] DISP_BLANK = 2'd0;
    localparam logic [1:0] DISP_BOMB  = 2'd1;
    localparam logic [1:0] DISP_WIN   = 2'd2;
    localparam logic [1:0] DISP_BOOM  = 2'd3;

    // Feedback taps for x^4 + x^3 + 1: bits 3 and 2 of the shift register.
    localparam logic [3:0] LFSR_TAPS = 4'b1100;

    // One shift of the 4-bit Fibonacci LFSR; new bit enters at the LSB.
    function automatic logic [3:0] lfsr_next(input logic [3:0] v);
        return {v[2:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/bomb_game_if.sv
`default_nettype none
// ============================================================================
// Interface : bomb_game_if
// Brief     : Board switches/buttons in, renderer controls and status out.
//             master = board side, slave = game sequencer.
// Revision  : 1.0 - initial release
// ============================================================================
interface bomb_game_if;
    logic       power_sw;
    logic       arm_btn;
    logic [3:0] wire_cut;
    logic       bomb_en;
    logic       fuse_run;
    logic [2:0] fuse_level;
    logic [1:0] disp_sel;
    logic [1:0] secret_idx;
    logic       win;
    logic       fail;
    logic       wires_err;
    logic [3:0] wins;
    logic [3:0] losses;

    modport master (
        output power_sw, arm_btn, wire_cut,
        input  bomb_en, fuse_run, fuse_level, disp_sel, secret_idx,
               win, fail, wires_err, wins, losses
    );

    modport slave (
        input  power_sw, arm_btn, wire_cut,
        output bomb_en, fuse_run, fuse_level, disp_sel, secret_idx,
               win, fail, wires_err, wins, losses
    );
endinterface
`default_nettype wire

// File: rtl/bomb_game_ctrl_fuse_timer.sv
`default_nettype none
// ============================================================================
// Module   : fuse_timer
// Brief    : Fuse pacing: tick divider, burned-row counter with penalty input
//            and clamp, and the burnt flag. burn_next warns the sequencer that
//            the update at this edge finishes the fuse.
// Revision : 1.0 - initial release
// ============================================================================
module fuse_timer #(
    parameter int TICK_DIV   = 2800,
    parameter int FUSE_STEPS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       clear,
    input  logic       penalty,
    output logic [2:0] level,
    output logic       burn_next
);
    localparam int             CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]  TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [3:0]     STEPS     = 4'(FUSE_STEPS);

    logic [CW-1:0] tick_cnt;
    logic          burnt;
    logic          active;
    logic          tick;
    logic          pen;
    logic [3:0]    sum;
    logic [2:0]    level_next;

    // Tick and penalty add up to two rows in one update; result clamps at the fuse end.
    always_comb begin
        active     = run && !burnt;
        tick       = active && (tick_cnt == TICK_LAST);
        pen        = active && penalty;
        sum        = {1'b0, level} + {3'b000, tick} + {3'b000, pen};
        level_next = sum[2:0];
        burn_next  = 1'b0;
        if (sum >= STEPS) begin
            level_next = STEPS[2:0];
            burn_next  = active;
        end
    end

    // Divider and row counter; clear restarts the fuse for a new round.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
            level    <= 3'd0;
            burnt    <= 1'b0;
        end else if (clear) begin
            tick_cnt <= '0;
            level    <= 3'd0;
            burnt    <= 1'b0;
        end else if (active) begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            level    <= level_next;
            burnt    <= burn_next;
        end
    end
endmodule
`default_nettype wire

// File: rtl/bomb_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bomb_game_ctrl
// Brief    : Round sequencer for the bomb board: power/arm/countdown FSM,
//            input edge detect, secret-wire LFSR, wire-cut judging, frame
//            select and saturating win/loss scores.
// Revision : 1.0 - initial release
// ============================================================================
module bomb_game_ctrl #(
    parameter int         TICK_DIV   = 2800,
    parameter int         FUSE_STEPS = 4,
    parameter logic [3:0] LFSR_SEED  = 4'b1001
) (
    input  logic       clk,
    input  logic       rst,
    bomb_game_if.slave bus
);
    import bomb_game_pkg::*;

    state_t     state, state_next;
    logic       arm_q, arm_rise;
    logic [3:0] wire_cut_q, cut_rise;
    logic [3:0] lfsr;
    logic       start, refuse, secret_hit, wrong_cut, arm_ok, arm_bad;
    logic       run, clear, penalty, burn_next;
    logic [2:0] level;
    logic [1:0] disp_next;
    logic       bomb_en, fuse_run, win, fail, wires_err;
    logic [1:0] disp_sel, secret_idx;
    logic [3:0] wins, losses;

    fuse_timer #(
        .TICK_DIV   (TICK_DIV),
        .FUSE_STEPS (FUSE_STEPS)
    ) u_fuse (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .clear     (clear),
        .penalty   (penalty),
        .level     (level),
        .burn_next (burn_next)
    );

    // Registered rising-edge pulses; wire_cut_q is the wire state seen with arm_rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arm_q      <= 1'b0;
            arm_rise   <= 1'b0;
            wire_cut_q <= 4'd0;
            cut_rise   <= 4'd0;
        end else begin
            arm_q      <= bus.arm_btn;
            arm_rise   <= bus.arm_btn & ~arm_q;
            wire_cut_q <= bus.wire_cut;
            cut_rise   <= bus.wire_cut & ~wire_cut_q;
        end
    end

    // Secret-wire source; frozen while the board is off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr <= LFSR_SEED;
        else if (state != ST_OFF) lfsr <= lfsr_next(lfsr);
    end

    // Next-state, fuse control and next frame select.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        refuse     = 1'b0;
        secret_hit = (cut_rise == (4'b0001 << secret_idx));
        wrong_cut  = (cut_rise != 4'd0) && !secret_hit;
        arm_ok     = arm_rise && (wire_cut_q == 4'd0);
        arm_bad    = arm_rise && (wire_cut_q != 4'd0);
        run        = (state == ST_COUNT) && bus.power_sw;
        penalty    = (state == ST_COUNT) && wrong_cut;
        case (state)
            ST_OFF: if (bus.power_sw) state_next = ST_IDLE;
            ST_IDLE, ST_DEFUSED, ST_EXPLODED: begin
                if (arm_ok) begin
                    state_next = ST_COUNT;
                    start      = 1'b1;
                end else if (arm_bad) begin
                    refuse = 1'b1;
                end
            end
            // Burning out wins over a concurrent secret cut.
            ST_COUNT: begin
                if (burn_next)       state_next = ST_EXPLODED;
                else if (secret_hit) state_next = ST_DEFUSED;
            end
            default: state_next = ST_OFF;
        endcase
        if (!bus.power_sw) begin
            state_next = ST_OFF;
            start      = 1'b0;
            refuse     = 1'b0;
        end
        clear = start || (state_next == ST_OFF) || (state_next == ST_IDLE);
        case (state_next)
            ST_IDLE, ST_COUNT: disp_next = DISP_BOMB;
            ST_DEFUSED:        disp_next = DISP_WIN;
            ST_EXPLODED:       disp_next = DISP_BOOM;
            default:           disp_next = DISP_BLANK;
        endcase
    end

    // State register and registered outputs, scores counted once on result entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_OFF;
            bomb_en    <= 1'b0;
            fuse_run   <= 1'b0;
            disp_sel   <= DISP_BLANK;
            win        <= 1'b0;
            fail       <= 1'b0;
            secret_idx <= 2'd0;
            wires_err  <= 1'b0;
            wins       <= 4'd0;
            losses     <= 4'd0;
        end else begin
            state    <= state_next;
            bomb_en  <= (state_next != ST_OFF);
            fuse_run <= (state_next == ST_COUNT);
            disp_sel <= disp_next;
            win      <= (state_next == ST_DEFUSED);
            fail     <= (state_next == ST_EXPLODED);
            if (state_next == ST_OFF) begin
                secret_idx <= 2'd0;
                wires_err  <= 1'b0;
            end else if (start) begin
                secret_idx <= lfsr[1:0];
                wires_err  <= 1'b0;
            end else if (refuse) begin
                wires_err <= 1'b1;
            end
            if (state_next == ST_DEFUSED && state != ST_DEFUSED && wins != 4'hF)
                wins <= wins + 4'd1;
            if (state_next == ST_EXPLODED && state != ST_EXPLODED && losses != 4'hF)
                losses <= losses + 4'd1;
        end
    end

    assign bus.bomb_en    = bomb_en;
    assign bus.fuse_run   = fuse_run;
    assign bus.fuse_level = level;
    assign bus.disp_sel   = disp_sel;
    assign bus.secret_idx = secret_idx;
    assign bus.win        = win;
    assign bus.fail       = fail;
    assign bus.wires_err  = wires_err;
    assign bus.wins       = wins;
    assign bus.losses     = losses;
endmodule
`default_nettype wire

// File: tb/tb_bomb_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bomb_game_ctrl
// Brief    : Scoreboard bench for bomb_game_ctrl. Stimulus pushes timestamped
//            expectations derived from the game rules; a monitor compares
//            them against the outputs on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bomb_game_ctrl;
    localparam int         TD   = 4;
    localparam int         FS   = 4;
    localparam logic [3:0] SEED = 4'b1001;

    localparam int F_BOMB = 0, F_RUN = 1, F_LVL = 2, F_DISP = 3, F_SEC = 4;
    localparam int F_WIN = 5, F_FAIL = 6, F_ERR = 7, F_WINS = 8, F_LOSS = 9;

    typedef struct {
        int    cyc;
        int    fld;
        int    val;
        string name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   m_wins = 0;
    int   m_losses = 0;
    logic [3:0] m_lfsr;
    logic       m_on;
    exp_t sbq[$];

    bomb_game_if bus();

    bomb_game_ctrl #(
        .TICK_DIV   (TD),
        .FUSE_STEPS (FS),
        .LFSR_SEED  (SEED)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Edge counter used to timestamp expectations.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] lfsr_step(input logic [3:0] v);
        int x, fb;
        x  = int'(v);
        fb = ((x >> 3) ^ (x >> 2)) & 1;
        return 4'(((x << 1) | fb) & 15);
    endfunction

    // Reference LFSR: advances on every edge while the board is powered.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_lfsr <= SEED;
            m_on   <= 1'b0;
        end else begin
            if (m_on) m_lfsr <= lfsr_step(m_lfsr);
            m_on <= bus.power_sw;
        end
    end

    function automatic int field(int f);
        case (f)
            F_BOMB:  return int'(bus.bomb_en);
            F_RUN:   return int'(bus.fuse_run);
            F_LVL:   return int'(bus.fuse_level);
            F_DISP:  return int'(bus.disp_sel);
            F_SEC:   return int'(bus.secret_idx);
            F_WIN:   return int'(bus.win);
            F_FAIL:  return int'(bus.fail);
            F_ERR:   return int'(bus.wires_err);
            F_WINS:  return int'(bus.wins);
            default: return int'(bus.losses);
        endcase
    endfunction

    // Monitor: pops every expectation due at this edge and compares it.
    always @(negedge clk) begin
        exp_t e;
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            e = sbq.pop_front();
            n_checks++;
            if (e.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s: check due at cycle %0d missed (now %0d), required %0d",
                         e.name, e.cyc, cyc, e.val);
            end else if (field(e.fld) != e.val) begin
                n_fail++;
                $display("FAIL %s @cycle %0d: got %0d, required %0d",
                         e.name, cyc, field(e.fld), e.val);
            end
        end
    end

    task automatic exp1(int c, string nm, int f, int v);
        exp_t e;
        e.cyc = c; e.fld = f; e.val = v; e.name = nm;
        sbq.push_back(e);
    endtask

    task automatic exp_state(int c, string tag, int bomb, int run, int disp, int lvl, int w, int fl);
        exp1(c, {tag, ".bomb_en"},    F_BOMB, bomb);
        exp1(c, {tag, ".fuse_run"},   F_RUN,  run);
        exp1(c, {tag, ".disp_sel"},   F_DISP, disp);
        exp1(c, {tag, ".fuse_level"}, F_LVL,  lvl);
        exp1(c, {tag, ".win"},        F_WIN,  w);
        exp1(c, {tag, ".fail"},       F_FAIL, fl);
    endtask

    task automatic exp_off(int c, string tag);
        exp_state(c, tag, 0, 0, 0, 0, 0, 0);
        exp1(c, {tag, ".secret_idx"}, F_SEC,  0);
        exp1(c, {tag, ".wires_err"},  F_ERR,  0);
        exp1(c, {tag, ".wins"},       F_WINS, m_wins);
        exp1(c, {tag, ".losses"},     F_LOSS, m_losses);
    endtask

    task automatic exp_entry(int c, string tag, logic [1:0] s);
        exp_state(c, tag, 1, 1, 1, 0, 0, 0);
        exp1(c, {tag, ".secret_idx"}, F_SEC, int'(s));
        exp1(c, {tag, ".wires_err"},  F_ERR, 0);
    endtask

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pulse arm; returns the edge where the decision lands and the LFSR bits it will use.
    task automatic arm(output int e0, output logic [1:0] s);
        bus.arm_btn = 1'b1;
        step();
        bus.arm_btn = 1'b0;
        s = m_lfsr[1:0];
        step();
        e0 = cyc;
    endtask

    function automatic int sat15(int v);
        return (v >= 15) ? 15 : v + 1;
    endfunction

    // kind: 0 no cut, 1 secret, 2 wrong wire, 3 secret+wrong; cut takes effect k edges after entry.
    task automatic play_round(int kind, int k, string tag);
        int         e0, hit, x, lvl, w, last;
        logic [1:0] s;
        logic [3:0] cut;
        arm(e0, s);
        exp_entry(e0, tag, s);
        x   = 0;
        hit = e0 + k;
        cut = 4'd0;
        if (kind == 0) begin
            for (int m = 1; m < FS; m++) exp1(e0 + m * TD, {tag, ".step"}, F_LVL, m);
            x = e0 + FS * TD;
        end else begin
            w = (int'(s) + int'($urandom_range(1, 3))) % 4;
            if (kind == 1)      cut = 4'(1 << s);
            else if (kind == 2) cut = 4'(1 << w);
            else                cut = 4'((1 << s) | (1 << w));
            if (kind == 1) begin
                m_wins = sat15(m_wins);
                exp_state(hit, {tag, ".defuse"}, 1, 0, 2, k / TD, 1, 0);
                exp1(hit, {tag, ".wins"}, F_WINS, m_wins);
                exp1(hit + 3, {tag, ".frozen"}, F_LVL, k / TD);
            end else begin
                lvl = k / TD + 1;
                if (lvl >= FS) begin
                    x = hit;
                end else begin
                    exp_state(hit, {tag, ".penalty"}, 1, 1, 1, lvl, 0, 0);
                    x = e0 + (FS - 1) * TD;
                end
            end
        end
        if (x != 0) begin
            m_losses = sat15(m_losses);
            exp_state(x, {tag, ".boom"}, 1, 0, 3, FS, 0, 1);
            exp1(x, {tag, ".losses"}, F_LOSS, m_losses);
        end
        if (kind != 0) begin
            step(k - 2);
            bus.wire_cut = cut;
        end
        last = (x != 0) ? x : hit + 3;
        while (cyc < last + 1) step();
        bus.wire_cut = 4'd0;
        step(2);
    endtask

    initial begin
        int         e0;
        logic [1:0] s;
        bus.power_sw = 1'b0;
        bus.arm_btn  = 1'b0;
        bus.wire_cut = 4'd0;
        rst          = 1'b1;
        step(3);
        rst = 1'b0;
        exp_off(cyc, "reset");
        step(2);
        exp1(cyc, "off_unpowered.bomb_en", F_BOMB, 0);

        bus.power_sw = 1'b1;
        step();
        exp_state(cyc, "idle", 1, 0, 1, 0, 0, 0);
        step(3);

        // Refused arm with a wire still cut, then a clean arm.
        bus.wire_cut = 4'b0010;
        step(2);
        arm(e0, s);
        exp_state(e0, "refused", 1, 0, 1, 0, 0, 0);
        exp1(e0, "refused.wires_err", F_ERR, 1);
        bus.wire_cut = 4'd0;
        step(2);
        exp1(cyc, "refused_hold.wires_err", F_ERR, 1);

        play_round(0, 0,  "burnout");
        play_round(1, 6,  "defuse_l1");
        play_round(2, 12, "wrong_on_tick");
        play_round(3, 3,  "both_l0");

        // Power drop mid-round aborts without scoring.
        arm(e0, s);
        exp_entry(e0, "pwr_round", s);
        step(5);
        bus.power_sw = 1'b0;
        step();
        exp_off(cyc, "pwr_drop");
        bus.power_sw = 1'b1;
        step();
        exp_state(cyc, "pwr_back", 1, 0, 1, 0, 0, 0);
        step(2);

        for (int i = 0; i < 12; i++)
            play_round(int'($urandom_range(0, 3)), int'($urandom_range(2, 15)), "random");

        // Asynchronous reset mid-round clears everything before the next edge.
        arm(e0, s);
        exp_entry(e0, "rst_round", s);
        step(5);
        #1;
        rst      = 1'b1;
        m_wins   = 0;
        m_losses = 0;
        exp_off(cyc, "async_rst");
        step();
        rst = 1'b0;
        step();
        exp_state(cyc, "rst_idle", 1, 0, 1, 0, 0, 0);
        step(2);

        for (int i = 0; i < 16; i++)
            play_round(1, int'($urandom_range(2, 15)), "win_streak");
        exp1(cyc, "wins_saturated", F_WINS, 15);

        step(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
